// File: rtl/mant_div_pkg.sv
// mant_div_pkg: shared definitions for the mantissa divider controller.
//   MANT_W      default mantissa width (hidden bit included)
//   CNT_W       iteration counter width for MANT_W
//   div_state_t controller FSM states
//   cnt_width() counter width for an arbitrary operand width
package mant_div_pkg;

  localparam int unsigned MANT_W = 24;
  localparam int unsigned CNT_W  = $clog2(MANT_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mant_div_ctrl_if.sv
// mant_div_ctrl_if: operand/result handshake bundle for mant_div_ctrl.
//   in_valid/in_ready/dividend/divisor          upstream operand channel
//   out_valid/out_ready/quotient/remainder      downstream result channel
//   busy, div_by_zero                           status
//   modport slave  : the divider controller
//   modport master : the block driving operands and taking results
interface mant_div_ctrl_if #(
  parameter int unsigned WIDTH = mant_div_pkg::MANT_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             div_by_zero;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, busy, div_by_zero
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, busy, div_by_zero
  );
endinterface

// File: rtl/mant_div_step.sv
// mant_div_step: one combinational restoring-division iteration.
//   a_in  [WIDTH:0]   partial remainder A
//   q_in  [WIDTH-1:0] dividend/quotient shift register Q
//   m_in  [WIDTH-1:0] divisor M
//   a_out, q_out      A and Q after shift, trial subtract and restore
module mant_div_step
  import mant_div_pkg::*;
#(
  parameter int unsigned WIDTH = MANT_W
) (
  input  logic [WIDTH:0]   a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH:0]   a_out,
  output logic [WIDTH-1:0] q_out
);

  // The shifted value is carried one bit wider than A so the trial
  // difference sign is exact regardless of A's top bit.
  logic [WIDTH+1:0] a_sh;
  logic [WIDTH+1:0] trial;

  always_comb begin
    a_sh  = {a_in, q_in[WIDTH-1]};
    trial = a_sh - {2'b00, m_in};
    if (trial[WIDTH+1]) begin
      a_out = a_sh[WIDTH:0];
      q_out = {q_in[WIDTH-2:0], 1'b0};
    end else begin
      a_out = trial[WIDTH:0];
      q_out = {q_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mant_div_ctrl.sv
// mant_div_ctrl: sequential restoring mantissa divider, one quotient bit per clock.
//   clk, rst  single clock, synchronous active-high reset
//   bus       mant_div_ctrl_if.slave (operand channel, result channel, busy, div_by_zero)
// FSM IDLE -> RUN -> DONE -> IDLE. Result appears WIDTH edges after accept and is
// held in DONE until out_ready.
// Optional macro DIV_ZERO_CHECK_EN: a zero divisor skips the iterations and
// reports div_by_zero; without it div_by_zero is tied low.
module mant_div_ctrl
  import mant_div_pkg::*;
#(
  parameter int unsigned WIDTH = MANT_W
) (
  input  logic            clk,
  input  logic            rst,
  mant_div_ctrl_if.slave  bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  div_state_t       state, state_n;
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH:0]   a_nx;
  logic [WIDTH-1:0] q_nx;
  logic             zero_skip;
  logic             last_iter;

  mant_div_step #(.WIDTH(WIDTH)) u_step (
    .a_in  (a_r),
    .q_in  (q_r),
    .m_in  (m_r),
    .a_out (a_nx),
    .q_out (q_nx)
  );

`ifdef DIV_ZERO_CHECK_EN
  logic dz_r;
  logic dbz_r;
  assign zero_skip       = dz_r;
  assign bus.div_by_zero = dbz_r;
`else
  assign zero_skip       = 1'b0;
  assign bus.div_by_zero = 1'b0;
`endif

  assign last_iter = (cnt_r == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_n = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (zero_skip || last_iter) state_n = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      q_r    <= '0;
      m_r    <= '0;
      cnt_r  <= '0;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          q_r   <= bus.dividend;
          m_r   <= bus.divisor;
          a_r   <= '0;
          cnt_r <= CW'(WIDTH);
        end
        RUN: if (zero_skip) begin
          // Q still holds the untouched dividend.
          quot_r <= '1;
          rem_r  <= q_r;
          cnt_r  <= '0;
        end else begin
          a_r   <= a_nx;
          q_r   <= q_nx;
          cnt_r <= cnt_r - CW'(1);
          if (last_iter) begin
            quot_r <= q_nx;
            rem_r  <= a_nx[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dz_r  <= 1'b0;
      dbz_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) dz_r <= (bus.divisor == '0);
        RUN:  if (dz_r) dbz_r <= 1'b1;
        DONE: if (bus.out_ready) begin
          dz_r  <= 1'b0;
          dbz_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end
`endif

  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;

endmodule

// File: tb/tb_mant_div_ctrl.sv
module tb_mant_div_ctrl;
  localparam int unsigned W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mant_div_ctrl_if #(.WIDTH(W)) bus ();

  mant_div_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all-ones quotient
  // and the dividend as remainder.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic f, output int lat);
    if (b == 0) begin
      q = '1;
      r = a;
`ifdef DIV_ZERO_CHECK_EN
      f = 1'b1;
      lat = 1;
`else
      f = 1'b0;
      lat = W;
`endif
    end else begin
      q = a / b;
      r = a % b;
      f = 1'b0;
      lat = W;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ef, input int elat, input int hold,
                        input string tag);
    int n;
    logic [W-1:0] q0, r0;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.out_valid && n < 100);
    chk({tag, "_latency"}, n, elat);
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_dbz"}, bus.div_by_zero, ef);
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_in_ready_done"}, bus.in_ready, 0);
    q0 = bus.quotient;
    r0 = bus.remainder;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, bus.out_valid, 1);
      chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
      chk({tag, "_hold_q"}, bus.quotient, q0);
      chk({tag, "_hold_r"}, bus.remainder, r0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_handoff_valid"}, bus.out_valid, 0);
    chk({tag, "_handoff_ready"}, bus.in_ready, 1);
    chk({tag, "_handoff_dbz"}, bus.div_by_zero, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic         mf;
    int           ml, n;
    bit           saw;

    vecs[0] = '{a: 24'd8,        b: 24'd3,   q: 24'd2,       r: 24'd2};
    vecs[1] = '{a: 24'd9,        b: 24'd2,   q: 24'd4,       r: 24'd1};
    vecs[2] = '{a: 24'd15,       b: 24'd4,   q: 24'd3,       r: 24'd3};
    vecs[3] = '{a: 24'd7,        b: 24'd1,   q: 24'd7,       r: 24'd0};
    vecs[4] = '{a: 24'd16777215, b: 24'd3,   q: 24'd5592405, r: 24'd0};
    vecs[5] = '{a: 24'd1000000,  b: 24'd50,  q: 24'd20000,   r: 24'd0};
    vecs[6] = '{a: 24'd12345678, b: 24'd123, q: 24'd100371,  r: 24'd45};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0, W, 0,
             $sformatf("vec%0d", i));

    // Back-pressure for 10 cycles in DONE.
    run_op(24'd12345678, 24'd123, 24'd100371, 24'd45, 1'b0, W, 10, "backpressure");

    // Zero divisor.
    model(24'd100, 24'd0, mq, mr, mf, ml);
    run_op(24'd100, 24'd0, 24'hFFFFFF, 24'd100, mf, ml, 0, "divzero");

    // Reset at iteration 10 aborts the operation.
    bus.dividend = 24'd8;
    bus.divisor  = 24'd3;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_q", bus.quotient, 0);
    chk("abort_r", bus.remainder, 0);
    saw = 1'b0;
    repeat (30) begin
      tick();
      if (bus.out_valid) saw = 1'b1;
    end
    chk("abort_no_valid", saw, 0);
    run_op(24'd9, 24'd2, 24'd4, 24'd1, 1'b0, W, 0, "after_abort");

    // in_valid held high across handoff.
    bus.dividend = 24'd15;
    bus.divisor  = 24'd4;
    bus.in_valid = 1'b1;
    tick();
    bus.dividend = 24'd100;
    bus.divisor  = 24'd7;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.out_valid && n < 100);
    chk("held_lat1", n, W);
    chk("held_q1", bus.quotient, 3);
    chk("held_r1", bus.remainder, 3);
    repeat (3) begin
      tick();
      chk("held_done_in_ready", bus.in_ready, 0);
      chk("held_done_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("held_idle_ready", bus.in_ready, 1);
    chk("held_idle_busy", bus.busy, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("held_accept_busy", bus.busy, 1);
    chk("held_accept_ready", bus.in_ready, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.out_valid && n < 100);
    chk("held_lat2", n, W);
    chk("held_q2", bus.quotient, 14);
    chk("held_r2", bus.remainder, 2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      if ($urandom_range(0, 9) == 0) rb = '0;
      else begin
        rb = W'($urandom) >> $urandom_range(0, 23);
        if (rb == 0) rb = 24'd1;
      end
      model(ra, rb, mq, mr, mf, ml);
      run_op(ra, rb, mq, mr, mf, ml, $urandom_range(0, 2), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
